mb_uart_rx: RTL and testbench



---
 rtl/mb_uart_pkg.sv | 34 +++
 rtl/mb_rx_sync.sv | 30 +++
 rtl/mb_uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_mb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_uart_pkg.sv
// Shared constants, state encoding and timing helpers for the Modbus-RTU receiver.
// Timing helpers take 64-bit arguments so CLK_FREQ*1750 cannot overflow.
package mb_uart_pkg;

    localparam int NONE = 0;
    localparam int ODD  = 1;
    localparam int EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic int calc_bps_cnt(input longint clk_freq, input longint bps);
        return int'(clk_freq / bps);
    endfunction

    // Above 19200 baud Modbus fixes t1.5/t3.5 at 750 us / 1750 us.
    function automatic int calc_t15_cnt(input longint clk_freq, input longint bps);
        if (bps > 19200)
            return int'(clk_freq * 750 / 1000000);
        return int'(33 * (clk_freq / bps) / 2);
    endfunction

    function automatic int calc_t35_cnt(input longint clk_freq, input longint bps);
        if (bps > 19200)
            return int'(clk_freq * 1750 / 1000000);
        return int'(77 * (clk_freq / bps) / 2);
    endfunction

endpackage

// File: rtl/mb_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect.
// All flops reset high (line idle) so reset release never produces an edge.
module mb_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rxd,
    output logic o_rxd,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rxd  = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/mb_uart_rx.sv
// Modbus-RTU serial receiver: configurable width/parity/stop bits with 3-sample
// majority voting, per-character error flags and t1.5/t3.5 silence detection.
module mb_uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_gap_err,
    output logic                 frame_end,
    output logic                 rx_busy
);
    import mb_uart_pkg::*;

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF    = BPS_CNT / 2;
    localparam int T15_CNT = calc_t15_cnt(CLK_FREQ, UART_BPS);
    localparam int T35_CNT = calc_t35_cnt(CLK_FREQ, UART_BPS);
    localparam int CW      = $clog2(BPS_CNT);
    localparam int IW      = $clog2(DATA_BITS);
    localparam int TW      = $clog2(T35_CNT + 1);

    localparam logic [CW-1:0] C_LAST  = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] C_S0    = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1    = CW'(HALF);
    localparam logic [CW-1:0] C_S2    = CW'(HALF + 1);
    localparam logic [TW-1:0] C_T15   = TW'(T15_CNT);
    localparam logic [TW-1:0] C_T35   = TW'(T35_CNT);
    localparam logic [IW-1:0] C_DLAST = IW'(DATA_BITS - 1);
    localparam logic          C_SLAST = (STOP_BITS == 2);
    localparam logic          C_ODD   = (PARITY == ODD);

    state_t               r_state;
    state_t               w_next;
    logic                 w_rxd;
    logic                 w_fall;
    logic [CW-1:0]        r_clk_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_gap;
    logic [TW-1:0]        r_idle_cnt;
    logic                 r_frame_open;
    logic                 w_start;
    logic                 w_eval;
    logic                 w_maj;
    logic                 w_done;
    logic                 w_close;
    logic                 w_open_eff;

    mb_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rxd  (uart_rxd),
        .o_rxd  (w_rxd),
        .o_fall (w_fall)
    );

    assign w_start    = (r_state == ST_IDLE) && w_fall;
    assign w_eval     = (r_state != ST_IDLE) && (r_clk_cnt == C_S2);
    assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
    assign w_done     = (r_state == ST_STOP) && w_eval && (r_stop_idx == C_SLAST);
    assign w_close    = r_frame_open && (r_idle_cnt == C_T35);
    // A frame closing on the same cycle as a new start edge counts as closed.
    assign w_open_eff = r_frame_open & ~w_close;
    assign rx_busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
        end else begin
            if (r_state == ST_IDLE || r_clk_cnt == C_LAST)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + 1'b1;
            if (r_clk_cnt == C_S0)
                r_s0 <= w_rxd;
            if (r_clk_cnt == C_S1)
                r_s1 <= w_rxd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START:  if (w_eval) w_next = w_maj ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_eval && r_bit_idx == C_DLAST)
                           w_next = (PARITY != NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_eval) w_next = ST_STOP;
            ST_STOP:   if (w_done) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_gap      <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_par_err  <= 1'b0;
                r_frm_err  <= 1'b0;
                r_gap      <= w_open_eff && (r_idle_cnt > C_T15);
            end
            if (w_eval) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    ST_PARITY: r_par_err <= w_maj ^ (^r_shift) ^ C_ODD;
                    ST_STOP: begin
                        if (!w_maj)
                            r_frm_err <= 1'b1;
                        r_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_gap_err    <= 1'b0;
        end else begin
            rx_valid <= w_done;
            if (w_done) begin
                rx_data       <= r_shift;
                rx_parity_err <= r_par_err;
                rx_frame_err  <= r_frm_err | ~w_maj;
                rx_gap_err    <= r_gap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt   <= '0;
            r_frame_open <= 1'b0;
            frame_end    <= 1'b0;
        end else begin
            frame_end <= w_close;
            if (r_state != ST_IDLE || w_start)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != C_T35)
                r_idle_cnt <= r_idle_cnt + 1'b1;
            if (rx_valid)
                r_frame_open <= 1'b1;
            else if (w_close)
                r_frame_open <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mb_uart_rx.sv
// Scoreboard bench for mb_uart_rx: four receivers (8N1, 8E1, 8N2, 7O1) at a
// reduced clock so the t3.5 timer fits the run; expected characters are queued by the driver.
module tb_mb_uart_rx;

    localparam int CLKF = 5000000;
    localparam int BAUD = 115200;
    localparam int NB   = CLKF / BAUD;
    localparam int HF   = NB / 2;
    localparam int T15  = (CLKF / 1000) * 750 / 1000;
    localparam int T35  = (CLKF / 1000) * 1750 / 1000;

    typedef struct {
        int         idx;
        logic [8:0] d;
        bit         pe;
        bit         fe;
        bit         ge;
        int         vcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rxd = 4'hF;
    logic [3:0] vld, pe, fe, ge, fend, busy;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;

    int nbits [4] = '{8, 8, 8, 7};
    int pmode [4] = '{0, 2, 0, 1};
    int nstop [4] = '{1, 1, 2, 1};

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb [$];
    int   last_v [4];
    bit   has [4];
    bit   pend [4];
    int   fe_at [4];
    int   fe_cnt [4];
    bit   prev_v [4];
    bit   prev_f [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mb_uart_rx #(.CLK_FREQ(CLKF), .UART_BPS(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_valid(vld[0]), .rx_data(d0),
        .rx_parity_err(pe[0]), .rx_frame_err(fe[0]), .rx_gap_err(ge[0]), .frame_end(fend[0]), .rx_busy(busy[0]));
    mb_uart_rx #(.CLK_FREQ(CLKF), .UART_BPS(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_valid(vld[1]), .rx_data(d1),
        .rx_parity_err(pe[1]), .rx_frame_err(fe[1]), .rx_gap_err(ge[1]), .frame_end(fend[1]), .rx_busy(busy[1]));
    mb_uart_rx #(.CLK_FREQ(CLKF), .UART_BPS(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_valid(vld[2]), .rx_data(d2),
        .rx_parity_err(pe[2]), .rx_frame_err(fe[2]), .rx_gap_err(ge[2]), .frame_end(fend[2]), .rx_busy(busy[2]));
    mb_uart_rx #(.CLK_FREQ(CLKF), .UART_BPS(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[3]), .rx_valid(vld[3]), .rx_data(d3),
        .rx_parity_err(pe[3]), .rx_frame_err(fe[3]), .rx_gap_err(ge[3]), .frame_end(fend[3]), .rx_busy(busy[3]));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic chk_near(input string nm, input int act, input int exp, input int tol);
        n_chk++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d +/-%0d", nm, act, exp, tol);
    endtask

    function automatic int dat(input int i);
        case (i)
            0: return int'(d0);
            1: return int'(d1);
            2: return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    function automatic bit near(input int a, input int b);
        return (a > b - 8) && (a < b + 8);
    endfunction

    // Monitor: pops the scoreboard on every rx_valid, checks frame_end timing.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (vld[i]) begin
                    exp_t e;
                    chk($sformatf("valid_pulse%0d", i), int'(prev_v[i]), 0);
                    if (sb.size() == 0) begin
                        chk($sformatf("spurious_valid%0d", i), int'(vld[i]), 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("inst%0d", i), i, e.idx);
                        chk($sformatf("data%0d", i), dat(i), int'(e.d));
                        chk($sformatf("parity_err%0d", i), int'(pe[i]), int'(e.pe));
                        chk($sformatf("frame_err%0d", i), int'(fe[i]), int'(e.fe));
                        chk($sformatf("gap_err%0d", i), int'(ge[i]), int'(e.ge));
                        chk_near($sformatf("latency%0d", i), cyc, e.vcyc, 1);
                    end
                end
                if (fend[i]) begin
                    chk($sformatf("fend_pulse%0d", i), int'(prev_f[i]), 0);
                    if (!pend[i]) begin
                        chk($sformatf("spurious_fend%0d", i), int'(fend[i]), 0);
                    end else begin
                        chk_near($sformatf("fend_time%0d", i), cyc, fe_at[i], 1);
                        pend[i] = 1'b0;
                    end
                    fe_cnt[i]++;
                end
                prev_v[i] = vld[i];
                prev_f[i] = fend[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_v[i] = 1'b0;
                prev_f[i] = 1'b0;
            end
        end
    end

    task automatic send_char(input int i, input logic [8:0] d, input int pforce, input int smask);
        exp_t       e;
        logic [8:0] m;
        bit         pcor, pbit;
        int         c0, sil, n;
        @(negedge clk);
        while (has[i] && (near(cyc + 2 - last_v[i], T15) || near(cyc + 2 - last_v[i], T35)))
            @(negedge clk);
        c0   = cyc;
        sil  = c0 + 2 - last_v[i];
        m    = 9'((1 << nbits[i]) - 1);
        pcor = (^(d & m)) ^ (pmode[i] == 1);
        pbit = (pforce < 0) ? pcor : pforce[0];
        n    = nbits[i] + ((pmode[i] != 0) ? 1 : 0) + nstop[i];
        e.idx  = i;
        e.d    = d & m;
        e.pe   = (pmode[i] != 0) && (pbit != pcor);
        e.fe   = ((smask & ((1 << nstop[i]) - 1)) != 0);
        e.ge   = has[i] && sil > T15 && sil < T35;
        e.vcyc = c0 + 2 + 1 + n * NB + HF + 2;
        sb.push_back(e);
        has[i]    = 1'b1;
        last_v[i] = e.vcyc;
        pend[i]   = 1'b1;
        fe_at[i]  = e.vcyc + T35 + 1;
        rxd[i] = 1'b0;
        repeat (NB) @(negedge clk);
        for (int b = 0; b < nbits[i]; b++) begin
            rxd[i] = d[b];
            repeat (NB) @(negedge clk);
        end
        if (pmode[i] != 0) begin
            rxd[i] = pbit;
            repeat (NB) @(negedge clk);
        end
        for (int s = 0; s < nstop[i]; s++) begin
            rxd[i] = ~smask[s];
            repeat (NB) @(negedge clk);
        end
        rxd[i] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), int'(vld[i]), 0);
            chk($sformatf("%s_data%0d", tag, i), dat(i), 0);
            chk($sformatf("%s_flags%0d", tag, i), int'({pe[i], fe[i], ge[i]}), 0);
            chk($sformatf("%s_fend%0d", tag, i), int'(fend[i]), 0);
            chk($sformatf("%s_busy%0d", tag, i), int'(busy[i]), 0);
        end
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 150000 cycles");
        $fatal(1);
    end

    initial begin
        int fc, g0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_char(0, 9'h0A5, -1, 0);
        repeat (100) @(negedge clk);
        send_char(1, 9'h003, 1, 0);
        repeat (50) @(negedge clk);
        send_char(1, 9'h003, 0, 0);
        repeat (50) @(negedge clk);
        send_char(2, 9'h096, -1, 2);
        repeat (50) @(negedge clk);
        send_char(3, 9'h055, -1, 0);
        repeat (50) @(negedge clk);

        // Short low glitch: rejected at the start-bit vote, silence timer restarts.
        @(negedge clk);
        g0 = cyc;
        rxd[0] = 1'b0;
        repeat (8) @(negedge clk);
        rxd[0] = 1'b1;
        chk("glitch_busy_hi", int'(busy[0]), 1);
        if (pend[0]) fe_at[0] = g0 + HF + 5 + T35 + 1;
        last_v[0] = g0 + HF + 5;
        repeat (HF + 10) @(negedge clk);
        chk("glitch_busy_lo", int'(busy[0]), 0);
        send_char(0, 9'h03C, -1, 0);
        repeat (40) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            int i, pf, sm;
            i  = $urandom_range(0, 3);
            pf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            sm = ($urandom_range(0, 4) == 0) ? (1 << (nstop[i] - 1)) : 0;
            send_char(i, 9'($urandom), pf, sm);
            repeat ($urandom_range(5, 300)) @(negedge clk);
        end

        // Inter-character gap inside a frame, then a single frame_end.
        for (int k = 0; k < T35 + 2000 && pend[1]; k++) @(negedge clk);
        chk("frame1_closed_before_gap", int'(pend[1]), 0);
        fc = fe_cnt[1];
        send_char(1, 9'h001, -1, 0);
        repeat (CLKF / 1000) @(negedge clk);
        send_char(1, 9'h003, -1, 0);
        repeat (T35 + 100) @(negedge clk);
        chk("gap_fend_count", fe_cnt[1] - fc, 1);
        repeat (2000) @(negedge clk);
        chk("gap_fend_none_further", fe_cnt[1] - fc, 1);

        // Reset during data bit 4 of a character on instance 0.
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (NB) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (4 * NB + NB / 2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            has[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (3 * NB) @(negedge clk);
        send_char(0, 9'h0F0, -1, 0);
        repeat (T35 + 100) @(negedge clk);

        for (int i = 0; i < 4; i++)
            chk($sformatf("final_frame_closed%0d", i), int'(pend[i]), 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
